// File: rtl/wb_timer.sv
// Wishbone classic timer slave: prescaled 32-bit up-counter with compare,
// sticky match flag and level interrupt; every access terminates one cycle later.
module wb_timer #(
  parameter int PRESC_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [31:0]        wb_dat_i,
  input  logic [3:0]         wb_sel_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic               irq_o
);

  localparam logic [2:0] ADR_CTRL     = 3'd0;
  localparam logic [2:0] ADR_PRESCALE = 3'd1;
  localparam logic [2:0] ADR_COUNT    = 3'd2;
  localparam logic [2:0] ADR_COMPARE  = 3'd3;
  localparam logic [2:0] ADR_STATUS   = 3'd4;

  logic [2:0]         ctrl_reg, ctrl_next;
  logic [PRESC_W-1:0] presc_reg, presc_next;
  logic [PRESC_W-1:0] pc_reg, pc_next;
  logic [31:0]        count_reg, count_next;
  logic [31:0]        compare_reg, compare_next;
  logic               match_reg, match_next;
  logic               ack_reg, ack_next;
  logic               err_reg, err_next;
  logic [31:0]        dat_reg, dat_next;

  logic [2:0]  idx;
  logic        req;
  logic        mapped;
  logic        wr_en;
  logic [31:0] wmask;
  logic [31:0] rdata;
  logic [31:0] presc_ext;
  logic        tick;
  logic        hit;
  logic        set_match;
  logic        unused_adr;

  assign idx    = wb_adr_i[4:2];
  assign req    = wb_cyc_i & wb_stb_i & ~ack_reg & ~err_reg;
  assign mapped = (idx <= ADR_STATUS);
  assign wr_en  = req & wb_we_i & mapped;

  // Address bits outside [4:2] were already decoded by the interconnect.
  assign unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign wmask[gi*8 +: 8] = {8{wb_sel_i[gi]}};
    end
  endgenerate

  assign tick      = ctrl_reg[0] & (pc_reg == presc_reg);
  assign hit       = (count_reg == compare_reg);
  assign set_match = tick & hit & ~(wr_en & (idx == ADR_COUNT));

  always_comb begin
    presc_ext = '0;
    presc_ext[PRESC_W-1:0] = presc_reg;
  end

  always_comb begin
    rdata = '0;
    case (idx)
      ADR_CTRL:     rdata = {29'd0, ctrl_reg};
      ADR_PRESCALE: rdata = presc_ext;
      ADR_COUNT:    rdata = count_reg;
      ADR_COMPARE:  rdata = compare_reg;
      ADR_STATUS:   rdata = {31'd0, match_reg};
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    ctrl_next    = ctrl_reg;
    presc_next   = presc_reg;
    pc_next      = pc_reg;
    count_next   = count_reg;
    compare_next = compare_reg;
    match_next   = match_reg;
    ack_next     = req & mapped;
    err_next     = req & ~mapped;
    dat_next     = '0;

    if (req && !wb_we_i) begin
      dat_next = rdata;
    end

    if (!ctrl_reg[0] || tick) begin
      pc_next = '0;
    end else begin
      pc_next = pc_reg + PRESC_W'(1);
    end

    if (tick) begin
      count_next = (hit && ctrl_reg[2]) ? 32'd0 : count_reg + 32'd1;
    end

    if (wr_en) begin
      case (idx)
        ADR_CTRL: begin
          ctrl_next = (wb_dat_i[2:0] & wmask[2:0]) | (ctrl_reg & ~wmask[2:0]);
        end
        ADR_PRESCALE: begin
          presc_next = (wb_dat_i[PRESC_W-1:0] & wmask[PRESC_W-1:0]) |
                       (presc_reg & ~wmask[PRESC_W-1:0]);
          pc_next    = '0;
        end
        ADR_COUNT: begin
          count_next = (wb_dat_i & wmask) | (count_reg & ~wmask);
        end
        ADR_COMPARE: begin
          compare_next = (wb_dat_i & wmask) | (compare_reg & ~wmask);
        end
        ADR_STATUS: begin
          if (wb_sel_i[0] && wb_dat_i[0]) begin
            match_next = 1'b0;
          end
        end
        default: begin
        end
      endcase
    end

    // A hardware match outranks a same-cycle software clear.
    if (set_match) begin
      match_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_reg    <= '0;
      presc_reg   <= '0;
      pc_reg      <= '0;
      count_reg   <= '0;
      compare_reg <= '0;
      match_reg   <= 1'b0;
      ack_reg     <= 1'b0;
      err_reg     <= 1'b0;
      dat_reg     <= '0;
    end else begin
      ctrl_reg    <= ctrl_next;
      presc_reg   <= presc_next;
      pc_reg      <= pc_next;
      count_reg   <= count_next;
      compare_reg <= compare_next;
      match_reg   <= match_next;
      ack_reg     <= ack_next;
      err_reg     <= err_next;
      dat_reg     <= dat_next;
    end
  end

  assign wb_ack_o = ack_reg;
  assign wb_err_o = err_reg;
  assign wb_dat_o = dat_reg;
  assign irq_o    = match_reg & ctrl_reg[1];

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: bus tasks queue the expected termination,
// a negedge monitor pops and compares whenever ack or err appears.
module tb_wb_timer;

  localparam logic [31:0] A_CTRL  = 32'h00;
  localparam logic [31:0] A_PRESC = 32'h04;
  localparam logic [31:0] A_COUNT = 32'h08;
  localparam logic [31:0] A_CMP   = 32'h0C;
  localparam logic [31:0] A_STAT  = 32'h10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [31:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        wb_err_o;
  logic        irq_o;

  wb_timer #(.PRESC_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_we_i  (wb_we_i),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .wb_err_o (wb_err_o),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  typedef struct packed {
    logic        err;
    logic        chk;
    logic [31:0] dat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_vec = 0;
  int   n_bad = 0;
  int   txn_n = 0;
  logic prev_term = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  always @(negedge clk) begin
    if (wb_ack_o || wb_err_o) begin
      check_val("term_pulse_width", {31'd0, prev_term}, 32'd0);
      if (sb_q.size() == 0) begin
        check_val("unexpected_term", 32'd1, 32'd0);
      end else begin
        mon_e = sb_q.pop_front();
        check_val("ack", {31'd0, wb_ack_o}, {31'd0, ~mon_e.err});
        check_val("err", {31'd0, wb_err_o}, {31'd0, mon_e.err});
        if (mon_e.chk) check_val("rdata", wb_dat_o, mon_e.dat);
        $display("txn %0d cyc %0d ack=%0b err=%0b dat=0x%08h", txn_n, cyc_n,
                 wb_ack_o, wb_err_o, wb_dat_o);
        txn_n++;
      end
    end
    prev_term = wb_ack_o | wb_err_o;
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called 1 time unit after a rising edge; the access is accepted on the next edge.
  task automatic bus(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input logic chk, input logic [31:0] exp_dat);
    exp_t e;
    e.err = (adr[4:2] > 3'd4);
    e.chk = chk;
    e.dat = exp_dat;
    sb_q.push_back(e);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = adr;
    wb_dat_i = dat;
    wb_sel_i = sel;
    @(posedge clk);
    #1;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    bus(1'b1, adr, dat, sel, 1'b0, 32'd0);
  endtask

  task automatic rd(input logic [31:0] adr, input logic [31:0] exp);
    bus(1'b0, adr, 32'd0, 4'h0, 1'b1, exp);
  endtask

  // Delay so the next access lands on an edge e with (e - base) % md == rem.
  task automatic align(input int base, input int md, input int rem);
    for (int i = 0; i < md; i++) begin
      if (((cyc_n + 1 - base) % md) != rem) idle(1);
    end
  endtask

  task automatic rd_all_zero();
    rd(A_CTRL, 32'd0);
    rd(A_PRESC, 32'd0);
    rd(A_COUNT, 32'd0);
    rd(A_CMP, 32'd0);
    rd(A_STAT, 32'd0);
  endtask

  int w;
  int w2;

  initial begin
    idle(3);
    check_val("rst_ack", {31'd0, wb_ack_o}, 32'd0);
    check_val("rst_err", {31'd0, wb_err_o}, 32'd0);
    check_val("rst_dat", wb_dat_o, 32'd0);
    check_val("rst_irq", {31'd0, irq_o}, 32'd0);
    reset_n = 1'b1;
    idle(1);
    rd_all_zero();

    // Byte lanes
    wr(A_CMP, 32'hAABBCCDD, 4'hF);
    wr(A_CMP, 32'h00000011, 4'h1);
    rd(A_CMP, 32'hAABBCC11);

    // Auto-reload with PRESCALE = 0: COUNT after edge w+k is k mod 4
    wr(A_PRESC, 32'd0, 4'hF);
    wr(A_CMP, 32'd3, 4'hF);
    w = cyc_n + 1;
    wr(A_CTRL, 32'h7, 4'hF);
    rd(A_COUNT, 32'((cyc_n - w) % 4));
    check_val("irq_before_match", {31'd0, irq_o}, 32'd0);
    idle(1);
    check_val("irq_on_match", {31'd0, irq_o}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      rd(A_COUNT, 32'((cyc_n - w) % 4));
      if (i % 2 == 1) idle(1);
    end
    rd(A_STAT, 32'd1);

    // W1C away from a match edge clears the flag
    align(w, 4, 1);
    wr(A_STAT, 32'd1, 4'h1);
    check_val("irq_after_w1c", {31'd0, irq_o}, 32'd0);

    // W1C on a match edge: set wins
    align(w, 4, 0);
    wr(A_STAT, 32'd1, 4'h1);
    check_val("irq_w1c_collide", {31'd0, irq_o}, 32'd1);
    rd(A_STAT, 32'd1);

    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_STAT, 32'd1, 4'h1);
    rd(A_STAT, 32'd0);
    check_val("irq_disabled", {31'd0, irq_o}, 32'd0);

    // Prescale = 2 and wrap: COUNT after edge e is FFFFFFFE + (e-w2)/3
    wr(A_PRESC, 32'd2, 4'hF);
    wr(A_COUNT, 32'hFFFFFFFE, 4'hF);
    wr(A_CMP, 32'd5, 4'hF);
    w2 = cyc_n + 1;
    wr(A_CTRL, 32'h1, 4'hF);
    for (int i = 0; i < 8; i++) begin
      rd(A_COUNT, 32'hFFFFFFFE + 32'((cyc_n - w2) / 3));
    end
    rd(A_STAT, 32'd0);

    // COUNT write on a tick edge wins over the increment
    align(w2, 3, 0);
    wr(A_COUNT, 32'h100, 4'hF);
    rd(A_COUNT, 32'h100);

    // Unmapped offsets leave every register untouched
    wr(A_CTRL, 32'd0, 4'hF);
    wr(A_COUNT, 32'h12345678, 4'hF);
    wr(A_PRESC, 32'hFFFFFFFF, 4'hF);
    rd(A_PRESC, 32'h0000FFFF);
    rd(32'h14, 32'd0);
    rd(32'h1C, 32'd0);
    wr(32'h14, 32'hFFFFFFFF, 4'hF);
    wr(32'h1C, 32'hFFFFFFFF, 4'hF);
    rd(A_CTRL, 32'd0);
    rd(A_PRESC, 32'h0000FFFF);
    rd(A_COUNT, 32'h12345678);
    rd(A_CMP, 32'd5);
    rd(A_STAT, 32'd0);
    rd(32'hFFFFFF08, 32'h12345678);

    // Asynchronous reset in the middle of an acknowledged read
    wr(A_PRESC, 32'd0, 4'hF);
    wr(A_COUNT, 32'd5, 4'hF);
    wr(A_CTRL, 32'h3, 4'hF);
    check_val("irq_pre_reset", {31'd0, irq_o}, 32'd1);
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = 1'b0;
    wb_adr_i = A_CMP;
    @(posedge clk);
    #1;
    check_val("ack_pre_reset", {31'd0, wb_ack_o}, 32'd1);
    check_val("dat_pre_reset", wb_dat_o, 32'd5);
    reset_n = 1'b0;
    #1;
    check_val("ack_in_reset", {31'd0, wb_ack_o}, 32'd0);
    check_val("dat_in_reset", wb_dat_o, 32'd0);
    check_val("irq_in_reset", {31'd0, irq_o}, 32'd0);
    idle(2);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    reset_n  = 1'b1;
    idle(1);
    rd_all_zero();
    check_val("irq_after_reset", {31'd0, irq_o}, 32'd0);

    idle(2);
    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
